fifo_fsm: RTL and testbench

//  Synchronous single-clock FIFO for byte streams. Control is an explicit state machine (EMPTY/PARTIAL/FULL).

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_mem.sv | 32 +++
 rtl/fifo_fsm.sv | 85 ++++++++
 tb/tb_fifo_fsm.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared state encoding and default sizing for the byte FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_ADDR_WIDTH = 3;

  // Binary state encoding; code 2'd3 is unused and recovers to ST_EMPTY.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array with a sync write port and a registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Storage write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; a same-cycle write to raddr is not visible until the next read.
  always_ff @(posedge clk) begin
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_fsm.sv
// Single-clock byte FIFO with EMPTY/PARTIAL/FULL control state machine.
module fifo_fsm
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic                  wr_acc, rd_acc;

  // Acceptance and next state, decided from the state at the start of the cycle.
  always_comb begin
    wr_acc  = wr_en && (state != ST_FULL);
    rd_acc  = rd_en && (state != ST_EMPTY);
    state_n = state;
    case (state)
      ST_EMPTY:   if (wr_acc) state_n = ST_PARTIAL;
      ST_PARTIAL: begin
        if (wr_acc && !rd_acc && count == CNT_LAST)     state_n = ST_FULL;
        else if (rd_acc && !wr_acc && count == CNT_ONE) state_n = ST_EMPTY;
      end
      ST_FULL:    if (rd_acc) state_n = ST_PARTIAL;
      default:    state_n = ST_EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_n;
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (wr_acc && !rd_acc)      count <= count + CNT_ONE;
      else if (rd_acc && !wr_acc) count <= count - CNT_ONE;
    end
  end

  // Flags come straight from the state register.
  always_comb begin
    empty = (state == ST_EMPTY);
    full  = (state == ST_FULL);
  end

  // Enables are gated by reset so a reset cycle never writes storage or moves data_out.
  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (wr_acc && !reset),
    .waddr(wr_ptr),
    .wdata(data_in),
    .re   (rd_acc && !reset),
    .raddr(rd_ptr),
    .rdata(data_out)
  );

endmodule

// File: tb/tb_fifo_fsm.sv
// Directed self-checking bench for fifo_fsm.
module tb_fifo_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;

  int total = 0;
  int bad   = 0;

  fifo_fsm #(
    .DATA_WIDTH(8),
    .DEPTH     (8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .data_in (data_in),
    .data_out(data_out),
    .full    (full),
    .empty   (empty)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_data(input string tag, input logic [7:0] exp);
    total++;
    assert (data_out === exp) else begin
      bad++;
      $error("FAIL %s data_out=%h expected=%h", tag, data_out, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic exp_empty, input logic exp_full);
    total++;
    assert ({empty, full} === {exp_empty, exp_full}) else begin
      bad++;
      $error("FAIL %s empty/full=%b%b expected=%b%b", tag, empty, full, exp_empty, exp_full);
    end
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;

    // 1. reset
    tick();
    reset = 1'b0;
    chk_flags("reset_flags", 1'b1, 1'b0);
    chk_data("reset_data", 8'h00);

    // 2. three writes then three reads
    push(8'h24);
    chk_flags("t2_first_write", 1'b0, 1'b0);
    push(8'h81);
    push(8'h09);
    chk_flags("t2_three_stored", 1'b0, 1'b0);
    pop(); chk_data("t2_rd0", 8'h24);
    pop(); chk_data("t2_rd1", 8'h81);
    chk_flags("t2_one_left", 1'b0, 1'b0);
    pop(); chk_data("t2_rd2", 8'h09);
    chk_flags("t2_drained", 1'b1, 1'b0);

    // 3. fill to full, dropped overflow write, drain
    for (int i = 0; i < 7; i++) push(8'(i));
    chk_flags("t3_seven", 1'b0, 1'b0);
    push(8'h07);
    chk_flags("t3_full", 1'b0, 1'b1);
    push(8'hFF);
    chk_flags("t3_overflow", 1'b0, 1'b1);
    chk_data("t3_overflow_data", 8'h09);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk_data($sformatf("t3_rd%0d", i), 8'(i));
      if (i == 0) chk_flags("t3_after_first_rd", 1'b0, 1'b0);
    end
    chk_flags("t3_drained", 1'b1, 1'b0);

    // 4. fill 5 then 10 cycles of simultaneous read/write
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    wr_en = 1'b1; rd_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      data_in = 8'h20 + 8'(k);
      tick();
      chk_data($sformatf("t4_rw%0d", k), (k < 5) ? 8'h10 + 8'(k) : 8'h20 + 8'(k - 5));
      chk_flags($sformatf("t4_flags%0d", k), 1'b0, 1'b0);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pop();
      chk_data($sformatf("t4_drain%0d", i), 8'h25 + 8'(i));
    end
    chk_flags("t4_drained", 1'b1, 1'b0);

    // 5. read while empty; read+write while full
    pop();
    chk_data("t5_empty_rd", 8'h29);
    chk_flags("t5_empty_rd_flags", 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
    chk_flags("t5_full", 1'b0, 1'b1);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    chk_data("t5_full_rw", 8'h30);
    chk_flags("t5_full_rw_flags", 1'b0, 1'b0);
    for (int i = 1; i < 8; i++) begin
      pop();
      chk_data($sformatf("t5_drain%0d", i), 8'h30 + 8'(i));
    end
    chk_flags("t5_drained", 1'b1, 1'b0);

    // 6. reset with entries stored; requests during reset are ignored
    push(8'h41); push(8'h42); push(8'h43);
    pop();
    chk_data("t6_pre_reset", 8'h41);
    reset = 1'b1; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h55;
    tick();
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk_flags("t6_reset_flags", 1'b1, 1'b0);
    chk_data("t6_reset_data", 8'h00);
    push(8'h99);
    chk_flags("t6_new_write", 1'b0, 1'b0);
    pop();
    chk_data("t6_new_read", 8'h99);
    chk_flags("t6_new_drained", 1'b1, 1'b0);
    pop();
    chk_data("t6_empty_hold", 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
